datapath: RTL and testbench
===========================

// Module: datapath
// PURPOSE
// - 16-bit datapath of the simple RISC CPU: 8x16 register file, A/B operand registers,
//   barrel shifter, 4-op ALU, result register C and 3-bit status register (Z,N,V).
// - Controlled cycle by cycle by the external FSM controller; all state updates on rising clk.
// PARAMETERS
// - none (data width fixed 16, 8 registers, PC width 8)
// PORTS
// - clk        in   1   clock, all registers update on rising edge
// - rst_n      in   1   asynchronous active-low reset
// - readnum    in   3   register file read select
// - vsel       in   4   one-hot writeback source select
// - loada      in   1   load A from register file read data
// - loadb      in   1   load B from register file read data
// - shift      in   2   shifter op applied to B
// - asel       in   1   1: ALU Ain = 16'd0; 0: Ain = A
// - bsel       in   1   1: ALU Bin = sximm5; 0: Bin = shifter output
// - ALUop      in   2   ALU operation
// - loadc      in   1   load C from ALU output
// - loads      in   1   load status register from ALU flags
// - writenum   in   3   register file write select
// - write      in   1   register file write enable
// - mdata      in   16  memory read data
// - sximm8     in   16  sign-extended 8-bit immediate
// - PC         in   8   program counter
// - sximm5     in   16  sign-extended 5-bit immediate
// - Z_out      out  1   status zero flag
// - N          out  1   status negative flag
// - V          out  1   status overflow flag
// - datapath_out out 16 contents of C
// BEHAVIOUR
// - Reset (rst_n=0, async): R0..R7, A, B, C, Z/N/V all 0; outputs 0 immediately.
// - Register file: instance REGFILE, registers R0..R7 hierarchically visible; read combinational
//   R[readnum]; on edge with write=1, R[writenum] <= data_in. Same-edge read+write: A/B get old value.
// - data_in mux: vsel 1000 mdata; 0100 sximm8; 0010 {8'b0,PC}; 0001 C; any other code (incl 0000) -> C.
// - A/B load on edge when loada/loadb=1, else hold.
// - Shifter on B: 00 pass; 01 LSL1 (lsb 0); 10 LSR1 (msb 0); 11 ASR1 (msb replicated).
// - ALU: 00 Ain+Bin; 01 Ain-Bin; 10 Ain&Bin; 11 ~Bin. Result mod 2^16.
// - Flags: Z = result==0; N = result[15]; V = signed overflow for 00/01, 0 for 10/11.
// - C <= ALU result when loadc=1; Z_out/N/V <= flags when loads=1; each holds otherwise.
// - Loop path: C written back while loadb/loadc stay high updates one stage per clock; no bypass.
// - Latency: regfile -> A/B 1 clk, -> C/status 1 clk, -> regfile 1 clk.
// CONFIGURATION
// - DATAPATH_ASR_EN defined: shift=11 is arithmetic right shift as above.
// - Not defined: shift=11 behaves as logical right shift (same as 10).
// TESTING
// - Write mdata=1..8 to R0..R7 (vsel=1000, one per clk) -> R0=1 ... R7=8.
// - R0=7, R1=2 via sximm8; A<=R1, B<=R0, ALUop=01, loadc/loads=1, vsel=0001 write R2
//   -> R2=16'hFFFB, Z=0, N=1, V=0.
// - R3=10, R4=5; A<=R3, B<=R4, shift=01, ALUop=00 -> R5=20, Z=0, N=0, V=0.
// - R6=7, R5=20: AND -> C=4; then B<=4, ALUop=11, vsel=0000 write R7 -> R7=16'hFFFB.
// - vsel=0010, PC=8'h81 write R4 -> R4=16'h0081; vsel=1000 mdata=32 -> R2=32.
// - Overflow: A=16'h7FFF, B=1, ADD -> C=16'h8000, N=1, V=1; assert rst_n=0 mid-op -> all regs/flags 0.

Source files
------------

// File: rtl/datapath_if.sv
// Controller <-> datapath bundle for the 16-bit RISC datapath.
// master: controller side (drives control, immediates, PC, memory data; reads status and C)
// slave : datapath side
interface datapath_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned PC_W   = 8;

  logic [SEL_W-1:0]  readnum;
  logic [3:0]        vsel;
  logic              loada;
  logic              loadb;
  logic [1:0]        shift;
  logic              asel;
  logic              bsel;
  logic [1:0]        ALUop;
  logic              loadc;
  logic              loads;
  logic [SEL_W-1:0]  writenum;
  logic              write;
  logic [DATA_W-1:0] mdata;
  logic [DATA_W-1:0] sximm8;
  logic [PC_W-1:0]   PC;
  logic [DATA_W-1:0] sximm5;
  logic              Z_out;
  logic              N;
  logic              V;
  logic [DATA_W-1:0] datapath_out;

  modport master (
    output readnum, vsel, loada, loadb, shift, asel, bsel, ALUop,
           loadc, loads, writenum, write, mdata, sximm8, PC, sximm5,
    input  Z_out, N, V, datapath_out
  );

  modport slave (
    input  readnum, vsel, loada, loadb, shift, asel, bsel, ALUop,
           loadc, loads, writenum, write, mdata, sximm8, PC, sximm5,
    output Z_out, N, V, datapath_out
  );
endinterface

// File: rtl/datapath.sv
// 16-bit datapath: 8x16 register file (instance REGFILE), A/B operand registers,
// shifter on B, 4-op ALU, result register C and Z/N/V status register.
// Ports: clk, rst_n (async active-low), bus (datapath_if.slave: control, immediates,
//        PC, mdata in; Z_out/N/V/datapath_out out, all registered).
// Build option: define DATAPATH_ASR_EN to make shift=11 an arithmetic right shift;
//               otherwise shift=11 is a logical right shift.

// Register file: combinational read, synchronous write.
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic [2:0]  writenum,
  input  logic [2:0]  readnum,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
);
  logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;

  // Individual registers kept as named flops so R0..R7 are visible by name.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R0 <= '0; R1 <= '0; R2 <= '0; R3 <= '0;
      R4 <= '0; R5 <= '0; R6 <= '0; R7 <= '0;
    end else if (write) begin
      case (writenum)
        3'd0: R0 <= data_in;
        3'd1: R1 <= data_in;
        3'd2: R2 <= data_in;
        3'd3: R3 <= data_in;
        3'd4: R4 <= data_in;
        3'd5: R5 <= data_in;
        3'd6: R6 <= data_in;
        default: R7 <= data_in;
      endcase
    end
  end

  // Read mux
  always_comb begin
    data_out = R0;
    case (readnum)
      3'd0: data_out = R0;
      3'd1: data_out = R1;
      3'd2: data_out = R2;
      3'd3: data_out = R3;
      3'd4: data_out = R4;
      3'd5: data_out = R5;
      3'd6: data_out = R6;
      default: data_out = R7;
    endcase
  end
endmodule

module datapath (
  input logic      clk,
  input logic      rst_n,
  datapath_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned PC_W   = 8;

  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [DATA_W-1:0] sh_out;
  logic [DATA_W-1:0] ain, bin;
  logic [DATA_W-1:0] alu_out;
  logic              alu_v;
  logic              z_q, n_q, v_q;

  // Writeback source; unrecognised one-hot codes fall back to C.
  always_comb begin
    data_in = c_q;
    case (bus.vsel)
      4'b1000: data_in = bus.mdata;
      4'b0100: data_in = bus.sximm8;
      4'b0010: data_in = {(DATA_W-PC_W)'(0), bus.PC};
      default: data_in = c_q;
    endcase
  end

  regfile REGFILE (
    .clk      (clk),
    .rst_n    (rst_n),
    .write    (bus.write),
    .writenum (bus.writenum),
    .readnum  (bus.readnum),
    .data_in  (data_in),
    .data_out (rd_data)
  );

  // Operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (bus.loada) a_q <= rd_data;
      if (bus.loadb) b_q <= rd_data;
    end
  end

  // Shifter on B
  always_comb begin
    sh_out = b_q;
    case (bus.shift)
      2'b00: sh_out = b_q;
      2'b01: sh_out = {b_q[DATA_W-2:0], 1'b0};
      2'b10: sh_out = {1'b0, b_q[DATA_W-1:1]};
`ifdef DATAPATH_ASR_EN
      default: sh_out = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
`else
      default: sh_out = {1'b0, b_q[DATA_W-1:1]};
`endif
    endcase
  end

  assign ain = bus.asel ? '0 : a_q;
  assign bin = bus.bsel ? bus.sximm5 : sh_out;

  // ALU; overflow only meaningful for add/subtract.
  always_comb begin
    alu_out = '0;
    alu_v   = 1'b0;
    case (bus.ALUop)
      2'b00: begin
        alu_out = ain + bin;
        alu_v   = (ain[DATA_W-1] == bin[DATA_W-1]) && (alu_out[DATA_W-1] != ain[DATA_W-1]);
      end
      2'b01: begin
        alu_out = ain - bin;
        alu_v   = (ain[DATA_W-1] != bin[DATA_W-1]) && (alu_out[DATA_W-1] != ain[DATA_W-1]);
      end
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  // Result and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      if (bus.loadc) c_q <= alu_out;
      if (bus.loads) begin
        z_q <= (alu_out == '0);
        n_q <= alu_out[DATA_W-1];
        v_q <= alu_v;
      end
    end
  end

  assign bus.datapath_out = c_q;
  assign bus.Z_out        = z_q;
  assign bus.N            = n_q;
  assign bus.V            = v_q;
endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the RISC datapath.
module tb_datapath;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  datapath_if dp ();

  datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] get_reg(input int n);
    case (n)
      0: return dut.REGFILE.R0;
      1: return dut.REGFILE.R1;
      2: return dut.REGFILE.R2;
      3: return dut.REGFILE.R3;
      4: return dut.REGFILE.R4;
      5: return dut.REGFILE.R5;
      6: return dut.REGFILE.R6;
      default: return dut.REGFILE.R7;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dp.readnum = 3'd0; dp.writenum = 3'd0; dp.vsel = 4'b0000;
    dp.loada = 1'b0; dp.loadb = 1'b0; dp.loadc = 1'b0; dp.loads = 1'b0;
    dp.write = 1'b0; dp.shift = 2'b00; dp.asel = 1'b0; dp.bsel = 1'b0;
    dp.ALUop = 2'b00;
  endtask

  task automatic wr_imm(input logic [2:0] n, input logic [15:0] v);
    idle(); dp.vsel = 4'b0100; dp.sximm8 = v; dp.writenum = n; dp.write = 1'b1;
    step(); idle();
  endtask

  task automatic wr_mem(input logic [2:0] n, input logic [15:0] v);
    idle(); dp.vsel = 4'b1000; dp.mdata = v; dp.writenum = n; dp.write = 1'b1;
    step(); idle();
  endtask

  task automatic wr_c(input logic [2:0] n, input logic [3:0] vs);
    idle(); dp.vsel = vs; dp.writenum = n; dp.write = 1'b1;
    step(); idle();
  endtask

  task automatic load_a(input logic [2:0] n);
    idle(); dp.readnum = n; dp.loada = 1'b1; step(); idle();
  endtask

  task automatic load_b(input logic [2:0] n);
    idle(); dp.readnum = n; dp.loadb = 1'b1; step(); idle();
  endtask

  task automatic alu(input logic [1:0] op, input logic [1:0] sh, input logic as,
                     input logic bs, input logic ld_s, input logic [15:0] sx5);
    idle(); dp.ALUop = op; dp.shift = sh; dp.asel = as; dp.bsel = bs;
    dp.sximm5 = sx5; dp.loadc = 1'b1; dp.loads = ld_s;
    step(); idle();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dp.datapath_out !== 16'h0) begin errors++; $display("FAIL reset_c got %h exp 0000", dp.datapath_out); end
    checks++; if ({dp.Z_out, dp.N, dp.V} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {dp.Z_out, dp.N, dp.V}); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (get_reg(i) !== 16'h0) begin errors++; $display("FAIL reset_R%0d got %h exp 0000", i, get_reg(i)); end
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_mdata();
    for (int i = 0; i < 8; i++) wr_mem(3'(i), 16'(i + 1));
    for (int i = 0; i < 8; i++) begin
      checks++; if (get_reg(i) !== 16'(i + 1)) begin errors++; $display("FAIL mdata_R%0d got %h exp %h", i, get_reg(i), 16'(i + 1)); end
    end
  endtask

  task automatic test_sub();
    wr_imm(3'd0, 16'd7);
    wr_imm(3'd1, 16'd2);
    load_a(3'd1);
    load_b(3'd0);
    alu(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0);
    checks++; if (dp.datapath_out !== 16'hFFFB) begin errors++; $display("FAIL sub_c got %h exp fffb", dp.datapath_out); end
    checks++; if ({dp.Z_out, dp.N, dp.V} !== 3'b010) begin errors++; $display("FAIL sub_flags got %b exp 010", {dp.Z_out, dp.N, dp.V}); end
    wr_c(3'd2, 4'b0001);
    checks++; if (get_reg(2) !== 16'hFFFB) begin errors++; $display("FAIL sub_R2 got %h exp fffb", get_reg(2)); end
  endtask

  task automatic test_shift_add();
    wr_imm(3'd3, 16'd10);
    wr_imm(3'd4, 16'd5);
    load_a(3'd3);
    load_b(3'd4);
    alu(2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0);
    checks++; if ({dp.Z_out, dp.N, dp.V} !== 3'b000) begin errors++; $display("FAIL lsl_add_flags got %b exp 000", {dp.Z_out, dp.N, dp.V}); end
    wr_c(3'd5, 4'b0001);
    checks++; if (get_reg(5) !== 16'd20) begin errors++; $display("FAIL lsl_add_R5 got %h exp 0014", get_reg(5)); end
  endtask

  task automatic test_and_not();
    wr_imm(3'd6, 16'd7);
    load_a(3'd6);
    load_b(3'd5);
    alu(2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0);
    checks++; if (dp.datapath_out !== 16'd4) begin errors++; $display("FAIL and_c got %h exp 0004", dp.datapath_out); end
    wr_c(3'd0, 4'b0001);
    load_b(3'd0);
    alu(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0);
    checks++; if ({dp.Z_out, dp.N, dp.V} !== 3'b010) begin errors++; $display("FAIL not_flags got %b exp 010", {dp.Z_out, dp.N, dp.V}); end
    wr_c(3'd7, 4'b0000);
    checks++; if (get_reg(7) !== 16'hFFFB) begin errors++; $display("FAIL not_R7 got %h exp fffb", get_reg(7)); end
  endtask

  task automatic test_pc_mdata();
    idle(); dp.vsel = 4'b0010; dp.PC = 8'h81; dp.writenum = 3'd4; dp.write = 1'b1;
    step(); idle();
    checks++; if (get_reg(4) !== 16'h0081) begin errors++; $display("FAIL pc_R4 got %h exp 0081", get_reg(4)); end
    wr_mem(3'd2, 16'd32);
    checks++; if (get_reg(2) !== 16'd32) begin errors++; $display("FAIL mdata_R2 got %h exp 0020", get_reg(2)); end
  endtask

  task automatic test_same_edge();
    // R1 holds 2; write 0x1234 to R1 on the same edge A loads from R1.
    idle(); dp.vsel = 4'b0100; dp.sximm8 = 16'h1234; dp.writenum = 3'd1;
    dp.write = 1'b1; dp.readnum = 3'd1; dp.loada = 1'b1;
    step(); idle();
    alu(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0);
    checks++; if (dp.datapath_out !== 16'd2) begin errors++; $display("FAIL same_edge_a got %h exp 0002", dp.datapath_out); end
    checks++; if (get_reg(1) !== 16'h1234) begin errors++; $display("FAIL same_edge_R1 got %h exp 1234", get_reg(1)); end
  endtask

  task automatic test_shift_ops();
    logic [15:0] asr_exp;
`ifdef DATAPATH_ASR_EN
    asr_exp = 16'hC000;
`else
    asr_exp = 16'h4000;
`endif
    wr_imm(3'd3, 16'h8001);
    load_b(3'd3);
    alu(2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 16'h0);
    checks++; if (dp.datapath_out !== 16'h4000) begin errors++; $display("FAIL lsr_c got %h exp 4000", dp.datapath_out); end
    alu(2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 16'h0);
    checks++; if (dp.datapath_out !== asr_exp) begin errors++; $display("FAIL sh11_c got %h exp %h", dp.datapath_out, asr_exp); end
    checks++; if (dp.N !== asr_exp[15]) begin errors++; $display("FAIL sh11_n got %b exp %b", dp.N, asr_exp[15]); end
    alu(2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 16'h0);
    checks++; if (dp.datapath_out !== 16'h0002) begin errors++; $display("FAIL lsl_c got %h exp 0002", dp.datapath_out); end
    alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 16'h0);
    checks++; if (dp.datapath_out !== 16'h8001) begin errors++; $display("FAIL pass_c got %h exp 8001", dp.datapath_out); end
    alu(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 16'hFFFD);
    checks++; if (dp.datapath_out !== 16'hFFFD) begin errors++; $display("FAIL imm5_c got %h exp fffd", dp.datapath_out); end
  endtask

  task automatic test_overflow_reset();
    wr_mem(3'd0, 16'h7FFF);
    wr_mem(3'd1, 16'h0001);
    load_a(3'd0);
    load_b(3'd1);
    alu(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0);
    checks++; if (dp.datapath_out !== 16'h8000) begin errors++; $display("FAIL ovf_c got %h exp 8000", dp.datapath_out); end
    checks++; if ({dp.Z_out, dp.N, dp.V} !== 3'b011) begin errors++; $display("FAIL ovf_flags got %b exp 011", {dp.Z_out, dp.N, dp.V}); end
    load_a(3'd1);
    alu(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0);
    checks++; if (dp.datapath_out !== 16'h0) begin errors++; $display("FAIL zero_c got %h exp 0000", dp.datapath_out); end
    checks++; if ({dp.Z_out, dp.N, dp.V} !== 3'b100) begin errors++; $display("FAIL zero_flags got %b exp 100", {dp.Z_out, dp.N, dp.V}); end
    alu(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
    checks++; if (dp.datapath_out !== 16'd2) begin errors++; $display("FAIL hold_c got %h exp 0002", dp.datapath_out); end
    checks++; if ({dp.Z_out, dp.N, dp.V} !== 3'b100) begin errors++; $display("FAIL hold_flags got %b exp 100", {dp.Z_out, dp.N, dp.V}); end
    wr_c(3'd6, 4'b0011);
    checks++; if (get_reg(6) !== 16'd2) begin errors++; $display("FAIL vsel_other_R6 got %h exp 0002", get_reg(6)); end
    // Reset asserted in the middle of a cycle with loads active.
    load_a(3'd0);
    dp.loadc = 1'b1; dp.loads = 1'b1; dp.loadb = 1'b1; dp.readnum = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dp.datapath_out !== 16'h0) begin errors++; $display("FAIL midrst_c got %h exp 0000", dp.datapath_out); end
    checks++; if ({dp.Z_out, dp.N, dp.V} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b exp 000", {dp.Z_out, dp.N, dp.V}); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (get_reg(i) !== 16'h0) begin errors++; $display("FAIL midrst_R%0d got %h exp 0000", i, get_reg(i)); end
    end
    idle();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    idle();
    dp.mdata = '0; dp.sximm8 = '0; dp.sximm5 = '0; dp.PC = '0;
    test_reset();
    test_write_mdata();
    test_sub();
    test_shift_add();
    test_and_not();
    test_pc_mdata();
    test_same_edge();
    test_shift_ops();
    test_overflow_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
